ctrl_seq: RTL

multi-cycle control sequencer that decodes one 10-bit instruction and drives the ALU's Ain/Gin/Gout/FN strobes, register-file bus enables and write-back.

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-002 CLKb  input  1  system clock; all state updates on the rising edge; the ALU samples strobes on the falling edge.
REQ-003 Clr  input  1  synchronous active-high reset.
REQ-004 Exec  input  1  start request, sampled only in IDLE.
REQ-005 INSTR  input  10  instruction: [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] ignored.
REQ-006 Ain, Gin, Gout  output  1 each  ALU A-load, B-load and compute strobes.
REQ-007 FN  output  4  ALU function code.
REQ-008 Rout  output  4  one-hot register-to-bus enable.
REQ-009 Rin  output  4  one-hot register write enable.
REQ-010 Qout  output  1  ALU result drives the bus.
REQ-011 ENW  output  1  external data drives the bus.
REQ-012 Busy  output  1  high in every state except IDLE.
REQ-013 Done  output  1  one-cycle completion pulse.
REQ-014 Err  output  1  reserved-opcode indicator.

Function
REQ-015 States SHALL be IDLE, T1, T2, T3, T4 and, under the macro only, TRAP.
REQ-016 All outputs SHALL be Moore-decoded from the registered state and the internal instruction register IR.
REQ-017 In IDLE with Exec=1, IR SHALL load INSTR at the same edge.
REQ-018 Next state from IDLE SHALL be:
- T1 for opcodes 0000/0001/0010/0011/0110-1011/1100-1111;
- T2 for unary opcodes 0100 (inv) and 0101 (flp).
REQ-019 Opcode 0000 (ldi), T1: ENW=1, Rin[Rx]=1, Done=1; next state IDLE.
REQ-020 Opcode 0001 (mov), T1: Rout[Ry]=1, Rin[Rx]=1, Done=1; next state IDLE.
REQ-021 Binary ALU opcodes 0010, 0011, 0110-1011 SHALL sequence:
- T1: Rout[Rx], Ain;
- T2: Rout[Ry], Gin;
- T3: Gout;
- T4: Qout, Rin[Rx], Done; then IDLE.
REQ-022 Unary opcodes SHALL sequence T2, T3, T4 exactly as REQ-021, skipping T1.
REQ-023 FN SHALL equal IR[9:6] in T1-T4 for ALU opcodes and 4'b0000 otherwise.
REQ-024 Reserved opcodes 1100-1111 without the macro: T1 asserts Done=1 and Err=1, no enables; next state IDLE.
REQ-025 Exec while Busy SHALL be ignored and IR SHALL hold; Exec held high restarts only from IDLE.
REQ-026 At most one bit of Rout and at most one bus driver (Rout, Qout, ENW) SHALL be active in any cycle.
REQ-027 Latency from the capture edge to Done: 1 cycle (ldi/mov/reserved), 3 cycles (unary), 4 cycles (binary).

Reset
REQ-028 Clr=1 SHALL force IDLE, IR=0 and all outputs 0 at the next rising edge, including mid-instruction.
REQ-029 Clr SHALL take priority over a simultaneous Exec.

Configuration
REQ-030 With CTRL_ILLEGAL_TRAP_EN defined, a reserved opcode SHALL enter TRAP with Err=1 sticky, Busy=1 and no Done, exiting only on Clr.
REQ-031 Without CTRL_ILLEGAL_TRAP_EN, REQ-024 SHALL apply and the TRAP state SHALL NOT exist.

Structure
REQ-032 Shared package ctrl_pkg SHALL hold the state enum, opcode constants (shared with ALU FN encoding) and INSTR field positions.
REQ-033 Sub-module onehot_dec (2-to-4 one-hot decoder with enable) SHALL generate Rout and Rin.

Verification
REQ-034 add R1,R2: INSTR=10'b0010011000, Exec=1 pulse -> T1 Rout=0010/Ain; T2 Rout=0100/Gin; T3 Gout with FN=0010; T4 Qout, Rin=0010, Done.
REQ-035 inv R3,R0: INSTR=10'b0100110000 -> no Ain at all; T2 Rout=0001/Gin; Done in 3rd cycle with Rin=1000.
REQ-036 ldi R2: INSTR=10'b0000100000 -> next cycle ENW=1, Rin=0100, Done=1, then Busy=0.
REQ-037 Clr asserted during T3 of a sub -> next cycle all outputs 0 and state IDLE; a new Exec one cycle later runs normally.
REQ-038 Exec held high across a binary op with INSTR changed mid-flight -> FN stays the original opcode; second instruction captured only in IDLE.
REQ-039 INSTR=10'b1111000000 -> Err+Done one cycle (macro off); Err sticky with Busy held until Clr (macro on).

---
 rtl/ctrl_pkg.sv | 54 +++++
 rtl/ctrl_seq_if.sv | 30 +++
 rtl/onehot_dec.sv | 16 +
 rtl/ctrl_seq.sv | 136 +++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: states, opcodes (same encoding as ALU FN), INSTR fields.
// Latency: n/a (package only).
// Backpressure: n/a. Optional build macro: CTRL_ILLEGAL_TRAP_EN adds the TRAP state.
package ctrl_pkg;

  // INSTR field positions
  localparam int OPC_MSB = 9;
  localparam int OPC_LSB = 6;
  localparam int RX_MSB  = 5;
  localparam int RX_LSB  = 4;
  localparam int RY_MSB  = 3;
  localparam int RY_LSB  = 2;

  // Opcodes; ALU opcodes double as the FN code seen by the ALU
  localparam logic [3:0] OP_LDI    = 4'h0;
  localparam logic [3:0] OP_MOV    = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_SUB    = 4'h3;
  localparam logic [3:0] OP_INV    = 4'h4;
  localparam logic [3:0] OP_FLP    = 4'h5;
  localparam logic [3:0] OP_BIN_LO = 4'h6;
  localparam logic [3:0] OP_BIN_HI = 4'hB;
  localparam logic [3:0] OP_RSV_LO = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
`ifdef CTRL_ILLEGAL_TRAP_EN
    S_T4   = 3'd4,
    S_TRAP = 3'd5
`else
    S_T4   = 3'd4
`endif
  } state_t;

  function automatic logic is_unary(input logic [3:0] op);
    return (op == OP_INV) || (op == OP_FLP);
  endfunction

  function automatic logic is_binary(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || ((op >= OP_BIN_LO) && (op <= OP_BIN_HI));
  endfunction

  function automatic logic is_alu(input logic [3:0] op);
    return is_unary(op) || is_binary(op);
  endfunction

  function automatic logic is_reserved(input logic [3:0] op);
    return op >= OP_RSV_LO;
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Bundle of the sequencer's start request, instruction and ALU/register-file strobes.
// Latency: n/a (wiring only).
// Backpressure: none; Exec is simply ignored while Busy is high.
interface ctrl_seq_if;
  logic       Exec;
  logic [9:0] INSTR;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic [3:0] FN;
  logic [3:0] Rout;
  logic [3:0] Rin;
  logic       Qout;
  logic       ENW;
  logic       Busy;
  logic       Done;
  logic       Err;

  // Requester side: issues instructions, observes strobes
  modport master (
    output Exec, INSTR,
    input  Ain, Gin, Gout, FN, Rout, Rin, Qout, ENW, Busy, Done, Err
  );

  // Sequencer side
  modport slave (
    input  Exec, INSTR,
    output Ain, Gin, Gout, FN, Rout, Rin, Qout, ENW, Busy, Done, Err
  );
endinterface

// File: rtl/onehot_dec.sv
// 2-to-4 one-hot decoder with enable; all-zero output when disabled.
// Latency: combinational.
// Backpressure: n/a.
module onehot_dec (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  // Single bit set at the selected index when enabled
  always_comb begin
    y = 4'b0000;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: decodes a captured instruction into ALU and register-file strobes.
// Latency: Done 1 cycle after capture (ldi/mov/reserved), 3 (unary), 4 (binary); outputs are Moore.
// Backpressure: Exec ignored while Busy; optional CTRL_ILLEGAL_TRAP_EN parks reserved opcodes in TRAP until Clr.
module ctrl_seq
  import ctrl_pkg::*;
(
  input logic     CLKb,
  input logic     Clr,
  ctrl_seq_if.slave bus
);

  state_t     state, nxt;
  logic [9:0] ir;

  logic [3:0] op;
  logic [1:0] rx, ry;
  logic       ain, gin, gout, qout, enw, busy, done, err;
  logic       rout_en, rin_en;
  logic [1:0] rout_sel;
  logic [3:0] fn;

  // Low instruction bits are carried in IR but never decoded
  logic unused_ir_lsb;
  assign unused_ir_lsb = ^ir[1:0];

  assign op = ir[OPC_MSB:OPC_LSB];
  assign rx = ir[RX_MSB:RX_LSB];
  assign ry = ir[RY_MSB:RY_LSB];

  // State and instruction register; IR only loads on a start from IDLE
  always_ff @(posedge CLKb) begin
    if (Clr) begin
      state <= S_IDLE;
      ir    <= 10'd0;
    end else begin
      state <= nxt;
      if ((state == S_IDLE) && bus.Exec) ir <= bus.INSTR;
    end
  end

  // Next-state and Moore strobe decode from state and IR
  always_comb begin
    nxt      = state;
    ain      = 1'b0;
    gin      = 1'b0;
    gout     = 1'b0;
    qout     = 1'b0;
    enw      = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    rout_en  = 1'b0;
    rout_sel = rx;
    rin_en   = 1'b0;
    busy     = (state != S_IDLE);
    fn       = ((state != S_IDLE) && is_alu(op)) ? op : 4'b0000;
    case (state)
      S_IDLE: begin
        // Unary ops have no A operand, so they skip the A-load step
        if (bus.Exec) nxt = is_unary(bus.INSTR[OPC_MSB:OPC_LSB]) ? S_T2 : S_T1;
      end
      S_T1: begin
        if (op == OP_LDI) begin
          enw    = 1'b1;
          rin_en = 1'b1;
          done   = 1'b1;
          nxt    = S_IDLE;
        end else if (op == OP_MOV) begin
          rout_en  = 1'b1;
          rout_sel = ry;
          rin_en   = 1'b1;
          done     = 1'b1;
          nxt      = S_IDLE;
        end else if (is_binary(op)) begin
          rout_en = 1'b1;
          ain     = 1'b1;
          nxt     = S_T2;
        end else if (is_reserved(op)) begin
          err = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
          nxt  = S_TRAP;
`else
          done = 1'b1;
          nxt  = S_IDLE;
`endif
        end else begin
          nxt = S_IDLE;
        end
      end
      S_T2: begin
        rout_en  = 1'b1;
        rout_sel = ry;
        gin      = 1'b1;
        nxt      = S_T3;
      end
      S_T3: begin
        gout = 1'b1;
        nxt  = S_T4;
      end
      S_T4: begin
        qout   = 1'b1;
        rin_en = 1'b1;
        done   = 1'b1;
        nxt    = S_IDLE;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        err = 1'b1;
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

  onehot_dec u_rout_dec (
    .en  (rout_en),
    .sel (rout_sel),
    .y   (bus.Rout)
  );

  onehot_dec u_rin_dec (
    .en  (rin_en),
    .sel (rx),
    .y   (bus.Rin)
  );

  assign bus.Ain  = ain;
  assign bus.Gin  = gin;
  assign bus.Gout = gout;
  assign bus.FN   = fn;
  assign bus.Qout = qout;
  assign bus.ENW  = enw;
  assign bus.Busy = busy;
  assign bus.Done = done;
  assign bus.Err  = err;

endmodule
